// File: rtl/idmem_wait.sv
// Unified instruction/data memory with LATENCY-cycle access, byte-enable writes and a req/ready/ack handshake.
// One transaction in flight; ready drops from acceptance until the edge after ack.
module idmem_wait #(
  parameter int    DEPTH     = 64,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = "memfile.dat"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            we_q;
  logic [3:0]      be_q;
  logic [31:0]     addr_q, wdata_q;
  logic [31:0]     mem [DEPTH];

  logic            cur_we;
  logic [3:0]      cur_be;
  logic [31:0]     cur_addr, cur_wdata;
  logic            bad_addr;
  logic            commit;
  logic [AW-1:0]   idx;

  assign ready = (state == IDLE) && !reset;
  assign ack   = (state == ACK);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (req) begin
        if (LATENCY == 1) begin
          state_nx = ACK;
        end else begin
          state_nx = WAIT;
          cnt_nx   = CNT_LOAD;
        end
      end
      WAIT: if (cnt == '0) state_nx = ACK;
            else           cnt_nx   = cnt - 1'b1;
      ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is the accepting edge, so the live inputs are used.
  always_comb begin
    cur_we    = we_q;
    cur_be    = be_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_we    = we;
      cur_be    = be;
      cur_addr  = addr;
      cur_wdata = wdata;
    end
  end

  // Full 30-bit word index is compared so out-of-range addresses never alias.
  assign bad_addr = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH));
  assign idx      = cur_addr[AW+1:2];
  assign commit   = (state_nx == ACK) && (state != ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req) begin
        we_q    <= we;
        be_q    <= be;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (commit) begin
        err   <= bad_addr;
        rdata <= (bad_addr || cur_we) ? 32'h0 : mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && cur_we && !bad_addr) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_idmem_wait.sv
// Randomised bench for idmem_wait at LATENCY 1, 2 and 15 against a word-array reference model.
module tb_idmem_wait;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic [2:0]  rst_a = 3'b111;
  logic [2:0]  req_a = 3'b000;
  logic [2:0]  we_a  = 3'b000;
  logic [3:0]  be_a    [3];
  logic [31:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic [2:0]  ready_a, ack_a, err_a;
  logic [31:0] rdata_a [3];

  logic [31:0] mdl [3][DEPTH];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    idmem_wait #(
      .DEPTH(DEPTH),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 15)),
      .INIT_FILE("")
    ) u_dut (
      .clk(clk), .reset(rst_a[g]), .req(req_a[g]), .ready(ready_a[g]),
      .we(we_a[g]), .be(be_a[g]), .addr(addr_a[g]), .wdata(wdata_a[g]),
      .ack(ack_a[g]), .rdata(rdata_a[g]), .err(err_a[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 15);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return {24'h0, $urandom_range(0, 255)} | 32'h1 << $urandom_range(0, 1);
      1:       return ($urandom() | 32'h100) & ~32'h3;
      default: return {22'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
    endcase
  endfunction

  // One transaction from an idle negedge; optionally keeps req high with junk while busy.
  task automatic xact(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic keep, output logic [31:0] rd);
    int lat = lat_of(k);
    int n = 1;
    int busy_rdy = 0;
    logic e;
    logic [31:0] exp_rd;
    e = addr_bad(a);
    exp_rd = e ? 32'h0 : mdl[k][a[7:2]];
    check($sformatf("u%0d_ready_idle", k), ready_a[k], 1);
    req_a[k] = 1'b1; we_a[k] = w; be_a[k] = b; addr_a[k] = a; wdata_a[k] = d;
    if (w && !e) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mdl[k][a[7:2]][8*i +: 8] = d[8*i +: 8];
    end
    tick();
    while (!ack_a[k] && n <= lat + 2) begin
      if (ready_a[k]) busy_rdy++;
      if (keep) begin
        we_a[k] = ~w; be_a[k] = 4'hF; addr_a[k] = $urandom() & 32'hFC; wdata_a[k] = $urandom();
      end else begin
        req_a[k] = 1'b0;
      end
      tick();
      n++;
    end
    check($sformatf("u%0d_latency", k), n, lat);
    check($sformatf("u%0d_ready_busy", k), busy_rdy, 0);
    check($sformatf("u%0d_ready_in_ack", k), ready_a[k], 0);
    check($sformatf("u%0d_err", k), err_a[k], e);
    if (!w) check($sformatf("u%0d_rdata", k), rdata_a[k], exp_rd);
    rd = rdata_a[k];
    req_a[k] = 1'b0;
    tick();
    check($sformatf("u%0d_ack_width", k), ack_a[k], 0);
    check($sformatf("u%0d_ready_after", k), ready_a[k], 1);
  endtask

  // req held high for reads: acks must be LATENCY+1 edges apart.
  task automatic back2back(input int k, input logic [31:0] a);
    int lat = lat_of(k);
    int cyc = 0;
    int prev = -1;
    int acks = 0;
    req_a[k] = 1'b1; we_a[k] = 1'b0; be_a[k] = 4'h0; addr_a[k] = a;
    while (acks < 3 && cyc < 4 * (lat + 1) + 4) begin
      tick();
      cyc++;
      if (ack_a[k]) begin
        acks++;
        if (prev < 0) check($sformatf("u%0d_b2b_first", k), cyc, lat);
        else          check($sformatf("u%0d_b2b_gap", k), cyc - prev, lat + 1);
        check($sformatf("u%0d_b2b_rdata", k), rdata_a[k], mdl[k][a[7:2]]);
        prev = cyc;
        if (acks == 3) req_a[k] = 1'b0;
      end
    end
    req_a[k] = 1'b0;
    check($sformatf("u%0d_b2b_count", k), acks, 3);
    tick();
  endtask

  // Write aborted by reset r edges after acceptance (r = LATENCY-1 hits the commit edge).
  task automatic abort_write(input int k, input logic [31:0] a, input logic [31:0] d, input int r);
    req_a[k] = 1'b1; we_a[k] = 1'b1; be_a[k] = 4'hF; addr_a[k] = a; wdata_a[k] = d;
    tick();
    req_a[k] = 1'b0;
    for (int i = 1; i < r; i++) begin
      check($sformatf("u%0d_abort_noack", k), ack_a[k], 0);
      tick();
    end
    rst_a[k] = 1'b1;
    tick();
    check($sformatf("u%0d_rst_ready", k), ready_a[k], 0);
    check($sformatf("u%0d_rst_ack", k), ack_a[k], 0);
    check($sformatf("u%0d_rst_err", k), err_a[k], 0);
    check($sformatf("u%0d_rst_rdata", k), rdata_a[k], 0);
    rst_a[k] = 1'b0;
    tick();
    check($sformatf("u%0d_post_rst_ready", k), ready_a[k], 1);
    check($sformatf("u%0d_post_rst_ack", k), ack_a[k], 0);
  endtask

  initial begin
    logic [31:0] rd;
    for (int k = 0; k < 3; k++) begin
      be_a[k] = 4'h0; addr_a[k] = '0; wdata_a[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d_reset_ready", k), ready_a[k], 0);
      check($sformatf("u%0d_reset_ack", k), ack_a[k], 0);
      check($sformatf("u%0d_reset_err", k), err_a[k], 0);
      check($sformatf("u%0d_reset_rdata", k), rdata_a[k], 0);
    end
    rst_a = 3'b000;
    tick();
    for (int k = 0; k < 3; k++) check($sformatf("u%0d_ready_first", k), ready_a[k], 1);

    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < DEPTH; w++)
        xact(k, 1'b1, 4'hF, 32'(w * 4), $urandom(), 1'b0, rd);

      xact(k, 1'b1, 4'hF, 32'h10, 32'hAABBCCDD, 1'b0, rd);
      xact(k, 1'b1, 4'b0101, 32'h10, 32'h11223344, 1'b1, rd);
      xact(k, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, rd);
      check($sformatf("u%0d_byte_merge", k), rd, 32'hAA22CC44);
      xact(k, 1'b1, 4'h0, 32'h10, 32'h55555555, 1'b0, rd);
      xact(k, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, rd);
      check($sformatf("u%0d_be_zero", k), rd, 32'hAA22CC44);

      xact(k, 1'b1, 4'hF, 32'h102, 32'h12345678, 1'b0, rd);
      xact(k, 1'b1, 4'hF, 32'h100, 32'h87654321, 1'b0, rd);
      xact(k, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, rd);
      xact(k, 1'b0, 4'h0, 32'hFC, 32'h0, 1'b0, rd);
      xact(k, 1'b1, 4'hF, 32'h4000_0000, 32'hCAFEF00D, 1'b0, rd);
      xact(k, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, rd);

      for (int t = 0; t < 40; t++)
        xact(k, 1'($urandom_range(0, 1)), 4'($urandom()), rand_addr(), $urandom(),
             1'($urandom_range(0, 1)), rd);

      back2back(k, 32'h10);
      back2back(k, {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00});

      if (lat_of(k) >= 2) begin
        abort_write(k, 32'h20, 32'hDEADBEEF, lat_of(k) - 1);
        xact(k, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, rd);
        for (int t = 0; t < 3; t++) begin
          logic [31:0] a;
          a = {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
          abort_write(k, a, $urandom(), $urandom_range(1, lat_of(k) - 1));
          xact(k, 1'b0, 4'h0, a, 32'h0, 1'b0, rd);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

endmodule
